// File: rtl/pc_redirect_if.sv
// Fetch-control bundle between the jump-condition unit, decode and the PC/redirect stage.
// master drives stall/jmp/target; slave returns the registered fetch PC and squash status.
interface pc_redirect_if #(
  parameter int ADDR_W = 16
);
  logic              stall;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic              redirect;
  logic              pending;

  modport master (
    output stall, jmp, jmp_target,
    input  pc, flush, redirect, pending
  );

  modport slave (
    input  stall, jmp, jmp_target,
    output pc, flush, redirect, pending
  );
endinterface

// File: rtl/pc_redirect.sv
// PC sequencer with edge-triggered branch redirect, wrong-path squash and stall-parked redirect.
// One-edge redirect latency; all outputs registered; stall freezes PC and the squash counter.
module pc_redirect #(
  parameter int                 ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int                 FLUSH_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  pc_redirect_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_PARK  = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_park;
  logic [2:0]        r_cnt;
  logic              r_jmp_q;
  logic              r_flush;
  logic              r_redirect;
  logic              r_pending;

  logic              w_req;
  logic [ADDR_W-1:0] w_pc_inc;

  // A level jmp only requests a redirect on its rising edge.
  assign w_req    = io_bus.jmp & ~r_jmp_q;
  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_park     <= '0;
      r_cnt      <= '0;
      r_jmp_q    <= 1'b0;
      r_flush    <= 1'b0;
      r_redirect <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      r_jmp_q    <= io_bus.jmp;
      r_redirect <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (!io_bus.stall) begin
            if (w_req) begin
              r_pc       <= io_bus.jmp_target;
              r_redirect <= 1'b1;
              r_cnt      <= FLUSH_INIT;
              r_flush    <= 1'b1;
              r_state    <= ST_FLUSH;
            end else begin
              r_pc <= w_pc_inc;
            end
          end else if (w_req) begin
            r_park    <= io_bus.jmp_target;
            r_pending <= 1'b1;
            r_state   <= ST_PARK;
          end
        end

        ST_PARK: begin
          if (w_req) begin
            r_park <= io_bus.jmp_target;
          end
          // A request landing on the release cycle is the newest target, so it wins.
          if (!io_bus.stall) begin
            r_pc       <= w_req ? io_bus.jmp_target : r_park;
            r_redirect <= 1'b1;
            r_cnt      <= FLUSH_INIT;
            r_flush    <= 1'b1;
            r_pending  <= 1'b0;
            r_state    <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          // Requests here come from squashed wrong-path instructions.
          if (!io_bus.stall) begin
            r_pc  <= w_pc_inc;
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
              r_flush <= 1'b0;
              r_state <= ST_RUN;
            end
          end
        end

        default: begin
          r_state   <= ST_RUN;
          r_flush   <= 1'b0;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.pc       = r_pc;
  assign io_bus.flush    = r_flush;
  assign io_bus.redirect = r_redirect;
  assign io_bus.pending  = r_pending;

endmodule

// File: tb/tb_pc_redirect.sv
// Directed-vector bench for pc_redirect: driver queues hand-computed post-edge outputs,
// an independent monitor pops one entry per clock and compares.
module tb_pc_redirect;

  localparam int ADDR_W = 16;

  typedef struct {
    logic [15:0] pc;
    logic        fl;
    logic        rd;
    logic        pd;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  pc_redirect_if #(.ADDR_W(ADDR_W)) bus ();

  pc_redirect #(
    .ADDR_W     (ADDR_W),
    .RESET_PC   (16'h0010),
    .FLUSH_DEPTH(2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic step(input logic r, input logic s, input logic j, input logic [15:0] tgt,
                      input logic [15:0] e_pc, input logic e_fl, input logic e_rd,
                      input logic e_pd, input string name);
    exp_t e;
    @(negedge clk);
    rst            = r;
    bus.stall      = s;
    bus.jmp        = j;
    bus.jmp_target = tgt;
    e.pc = e_pc; e.fl = e_fl; e.rd = e_rd; e.pd = e_pd; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.pc !== e.pc || bus.flush !== e.fl || bus.redirect !== e.rd ||
            bus.pending !== e.pd) begin
          failures++;
          $display("FAIL %s: got pc=%h flush=%b redirect=%b pending=%b, want pc=%h flush=%b redirect=%b pending=%b",
                   e.name, bus.pc, bus.flush, bus.redirect, bus.pending,
                   e.pc, e.fl, e.rd, e.pd);
        end
      end
    end
  end

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus.stall      = 1'b0;
    bus.jmp        = 1'b0;
    bus.jmp_target = '0;

    // reset and free-run
    step(1, 0, 0, 16'h0000, 16'h0010, 0, 0, 0, "reset0");
    step(1, 0, 0, 16'h0000, 16'h0010, 0, 0, 0, "reset1");
    step(0, 0, 0, 16'h0000, 16'h0011, 0, 0, 0, "run1");
    step(0, 0, 0, 16'h0000, 16'h0012, 0, 0, 0, "run2");
    step(0, 0, 0, 16'h0000, 16'h0013, 0, 0, 0, "run3");
    step(0, 0, 0, 16'h0000, 16'h0014, 0, 0, 0, "run4");

    // reach pc=0x0005 via a jump to 0x0003
    step(0, 0, 1, 16'h0003, 16'h0003, 1, 1, 0, "jmp3");
    step(0, 0, 0, 16'h0000, 16'h0004, 1, 0, 0, "jmp3_f1");
    step(0, 0, 0, 16'h0000, 16'h0005, 0, 0, 0, "jmp3_done");

    // single-cycle jmp pulse to 0x0040
    step(0, 0, 1, 16'h0040, 16'h0040, 1, 1, 0, "jmp40");
    step(0, 0, 0, 16'h0000, 16'h0041, 1, 0, 0, "jmp40_f1");
    step(0, 0, 0, 16'h0000, 16'h0042, 0, 0, 0, "jmp40_done");

    // jmp held high for 5 cycles: one redirect only
    step(0, 0, 1, 16'h0040, 16'h0040, 1, 1, 0, "hold1");
    step(0, 0, 1, 16'h0040, 16'h0041, 1, 0, 0, "hold2");
    step(0, 0, 1, 16'h0040, 16'h0042, 0, 0, 0, "hold3");
    step(0, 0, 1, 16'h0040, 16'h0043, 0, 0, 0, "hold4");
    step(0, 0, 1, 16'h0040, 16'h0044, 0, 0, 0, "hold5");
    step(0, 0, 0, 16'h0000, 16'h0045, 0, 0, 0, "hold_end");

    // redirect parked behind stall, latest target wins
    step(0, 1, 1, 16'h0080, 16'h0045, 0, 0, 1, "park80");
    step(0, 1, 0, 16'h0080, 16'h0045, 0, 0, 1, "park_gap");
    step(0, 1, 1, 16'h0090, 16'h0045, 0, 0, 1, "park90");
    step(0, 1, 1, 16'h0090, 16'h0045, 0, 0, 1, "park_hold");
    step(0, 0, 0, 16'h0000, 16'h0090, 1, 1, 0, "park_release");
    step(0, 0, 0, 16'h0000, 16'h0091, 1, 0, 0, "park_f1");
    step(0, 0, 0, 16'h0000, 16'h0092, 0, 0, 0, "park_done");

    // ignored requests and stalls inside FLUSH
    step(0, 0, 1, 16'h0200, 16'h0200, 1, 1, 0, "jmp200");
    step(0, 1, 0, 16'h0000, 16'h0200, 1, 0, 0, "fl_stall1");
    step(0, 1, 1, 16'h0100, 16'h0200, 1, 0, 0, "fl_stall2_req");
    step(0, 0, 0, 16'h0000, 16'h0201, 1, 0, 0, "fl_adv1");
    step(0, 0, 1, 16'h0100, 16'h0202, 0, 0, 0, "fl_req_ignored");
    step(0, 0, 0, 16'h0000, 16'h0203, 0, 0, 0, "fl_after");

    // back-to-back request in RUN is accepted
    step(0, 0, 1, 16'h0300, 16'h0300, 1, 1, 0, "b2b_jmp");
    step(0, 0, 0, 16'h0000, 16'h0301, 1, 0, 0, "b2b_f1");
    step(0, 0, 0, 16'h0000, 16'h0302, 0, 0, 0, "b2b_run");
    step(0, 0, 1, 16'h0400, 16'h0400, 1, 1, 0, "b2b_again");
    step(0, 0, 0, 16'h0000, 16'h0401, 1, 0, 0, "b2b_again_f1");
    step(0, 0, 0, 16'h0000, 16'h0402, 0, 0, 0, "b2b_again_run");

    // wrap at all-ones
    step(0, 0, 1, 16'hFFFE, 16'hFFFE, 1, 1, 0, "jmpFFFE");
    step(0, 0, 0, 16'h0000, 16'hFFFF, 1, 0, 0, "wrap_ffff");
    step(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "wrap_0000");
    step(0, 0, 0, 16'h0000, 16'h0001, 0, 0, 0, "wrap_0001");

    // reset mid-FLUSH
    step(0, 0, 1, 16'h0500, 16'h0500, 1, 1, 0, "jmp500");
    step(1, 0, 0, 16'h0000, 16'h0010, 0, 0, 0, "rst_flush");
    step(0, 0, 0, 16'h0000, 16'h0011, 0, 0, 0, "rst_flush_run");

    // reset mid-PARK discards the target
    step(0, 1, 1, 16'h0600, 16'h0011, 0, 0, 1, "park600");
    step(1, 1, 0, 16'h0000, 16'h0010, 0, 0, 0, "rst_park");
    step(0, 0, 0, 16'h0000, 16'h0011, 0, 0, 0, "rst_park_run");

    // request coincident with reset is lost
    step(1, 0, 1, 16'h0700, 16'h0010, 0, 0, 0, "rst_req");
    step(0, 0, 0, 16'h0000, 16'h0011, 0, 0, 0, "rst_req_lost");

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_redirect.md
# pc_redirect

Program-counter and branch-redirect stage, directly downstream of the jump-condition unit. It consumes that unit's level `jmp` decision together with the branch target from decode. It sequences the fetch address for instruction memory and squashes wrong-path instructions already in flight. It also parks a redirect that arrives during a pipeline stall until fetch can advance.

## Interface
Parameters:
- `ADDR_W`, 16, width of the instruction-memory word address.
- `RESET_PC`, 0, fetch address loaded on reset.
- `FLUSH_DEPTH`, 2, number of fetch slots between fetch and jump resolution (1..7); sets the squash length.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `stall`  in  1  pipeline hold; PC and flush counter freeze while high.
- `jmp`  in  1  level jump decision from the jump-condition unit; may stay high for several cycles per branch.
- `jmp_target`  in  ADDR_W  branch target, valid whenever `jmp` is high.
- `pc`  out  ADDR_W  current fetch address to instruction memory.
- `flush`  out  1  high while fetch/decode must discard their instruction.
- `redirect`  out  1  one-cycle pulse on the edge where `pc` is loaded from a target.
- `pending`  out  1  high while a redirect is parked behind `stall`.

## Operation
- Edge detect: `jmp_q` registers `jmp`. A redirect request is `jmp & ~jmp_q`. A level held high never triggers twice.
- State machine has three states: RUN, FLUSH, PARK.
- RUN behaviour:
  - `!stall`, no request: `pc <= pc + 1`, modulo 2^ADDR_W. `pc` wraps from all-ones to 0 with no flag.
  - `!stall`, request: `pc <= jmp_target`, `redirect` pulses, counter `<= FLUSH_DEPTH`, go to FLUSH.
  - `stall`, request: latch `jmp_target` into the park register, go to PARK. `pc` holds.
  - `stall`, no request: hold.
- PARK behaviour:
  - `pending` is high throughout.
  - A new request while parked overwrites the park register; the latest target wins.
  - On the first `!stall` cycle: `pc <= park register`, `redirect` pulses, counter `<= FLUSH_DEPTH`, go to FLUSH.
- FLUSH behaviour:
  - `flush` is high throughout.
  - `!stall`: `pc <= pc + 1` and the counter decrements. When the counter reaches 1 and decrements, return to RUN.
  - `stall`: PC and counter hold.
  - Requests arriving in FLUSH come from squashed instructions and are ignored. `jmp_q` still tracks `jmp`.
- Reset takes priority over everything: `pc = RESET_PC`, `flush = 0`, `redirect = 0`, `pending = 0`, `jmp_q = 0`, counter = 0, state RUN, park register = 0.
- Reset asserted mid-FLUSH or mid-PARK discards the flush and the parked target.

## Timing
- Redirect latency is one edge. A request seen before edge N gives `pc = jmp_target` and `redirect = 1` after edge N.
- `flush` rises after the same edge N and stays high for exactly FLUSH_DEPTH non-stalled cycles. It falls after the FLUSH_DEPTH-th non-stalled edge.
- A parked redirect is applied on the first rising edge with `stall = 0`. From that edge, timing is identical to an unstalled redirect.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A request coincident with `rst` is lost.
- Back-to-back requests:
  - `jmp` low for one cycle and then high again during FLUSH: ignored.
  - The same pattern in RUN: accepted.

## Test plan
- Reset with RESET_PC=0x0010, then 4 free-running cycles: `pc` reads 0x0010, 0x0011, 0x0012, 0x0013, 0x0014; `flush`=0 throughout.
- At pc=0x0005, pulse `jmp` with `jmp_target=0x0040`, FLUSH_DEPTH=2: next `pc`=0x0040 and `redirect`=1 for 1 cycle. `flush`=1 for the cycles where `pc`=0x0040 and 0x0041, then 0 at 0x0042.
- Hold `jmp` high for 5 cycles with target 0x0040: exactly one `redirect` pulse; the PC does not reload on later cycles.
- Raise `stall` with `jmp` rising (target 0x0080), then change `jmp_target` to 0x0090 with a fresh edge while stall persists for 3 cycles. `pending`=1 and `pc` holds. On release, `pc`=0x0090 and `redirect` pulses.
- During FLUSH, give `jmp` a new rising edge with target 0x0100: ignored, so `pc` continues incrementing from the first target. Also stall for 2 cycles mid-flush: `flush` is extended by 2 cycles.
- Start at pc=0xFFFF (ADDR_W=16) with no jump: `pc` wraps to 0x0000. Assert `rst` mid-FLUSH: next cycle `pc`=RESET_PC and `flush`=0.
